// File: rtl/seq_mux.sv
// seq_mux: registered N-channel word selector with direct and sequence modes.
// Sequence mode streams channels 0..LAST one word per VALID/READY handshake.
module seq_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 11,
    parameter int SELW  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCH*WIDTH-1:0]   IN,
    input  logic                   MODE,
    input  logic [SELW-1:0]        SEL,
    input  logic                   START,
    input  logic [SELW-1:0]        LAST,
    input  logic                   READY,
    output logic [WIDTH-1:0]       OUT,
    output logic                   VALID,
    output logic [SELW-1:0]        CH,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ERR
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);
    state_t state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0] ch_q, ch_d, last_q, last_d, ch_next;
    logic valid_q, valid_d, done_q, done_d, err_q, err_d, sel_ok, last_ok;
    logic [WIDTH-1:0] chans [2**SELW];
    // Unused slots read as zero so any index yields a defined word
    for (genvar k = 0; k < 2**SELW; k++) begin : g_ch
        if (k < NCH) begin : g_real
            assign chans[k] = IN[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chans[k] = '0;
        end
    end
    assign sel_ok  = {1'b0, SEL} < NCH_W;
    assign last_ok = {1'b0, LAST} < NCH_W;
    assign ch_next = ch_q + SELW'(1);
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ch_d    = ch_q;
        last_d  = last_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (!MODE) begin
                valid_d = sel_ok;
                err_d   = !sel_ok;
                out_d   = sel_ok ? chans[SEL] : out_q;
                ch_d    = sel_ok ? SEL : ch_q;
            end else if (!START) begin
                valid_d = 1'b0;
            end else if (!last_ok) begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                last_d  = LAST;
                err_d   = 1'b0;
                out_d   = chans[0];
                ch_d    = '0;
                valid_d = 1'b1;
                state_d = RUN;
            end
        end else if (valid_q && READY) begin
            if (ch_q == last_q) begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                ch_d  = ch_next;
                out_d = chans[ch_next];
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            out_q   <= '0;
            ch_q    <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign OUT   = out_q;
    assign VALID = valid_q;
    assign CH    = ch_q;
    assign BUSY  = state_q == RUN;
    assign DONE  = done_q;
    assign ERR   = err_q;
endmodule

// File: tb/tb_seq_mux.sv
// tb_seq_mux: scoreboard bench; each driven cycle queues the outputs expected after the next edge.
module tb_seq_mux;
    localparam int WIDTH = 8, NCH = 11, SELW = 4;
    typedef struct {
        string      tag;
        logic [7:0] out;
        logic       valid;
        logic [3:0] ch;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;
    logic CLK = 1'b0, RST = 1'b1, MODE = 1'b0, START = 1'b0, READY = 1'b0;
    logic [NCH*WIDTH-1:0] in_v;
    logic [SELW-1:0] SEL = '0, LAST = '0, CH;
    logic [WIDTH-1:0] OUT;
    logic VALID, BUSY, DONE, ERR;
    int errs = 0, checks = 0;
    exp_t sb[$];
    exp_t e;
    seq_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK(CLK), .RST(RST), .IN(in_v), .MODE(MODE), .SEL(SEL), .START(START),
        .LAST(LAST), .READY(READY), .OUT(OUT), .VALID(VALID), .CH(CH),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t ex(input string t, input logic [7:0] o, input logic v,
                                input logic [3:0] c, input logic b, input logic d, input logic er);
        ex = '{t, o, v, c, b, d, er};
    endfunction
    task automatic cyc(input logic r, input logic m, input logic [3:0] s, input logic st,
                       input logic [3:0] l, input logic rd, input exp_t x);
        @(posedge CLK);
        #2;
        RST = r; MODE = m; SEL = s; START = st; LAST = l; READY = rd;
        sb.push_back(x);
    endtask
    always begin
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".out"}, 32'(OUT), 32'(e.out));
            check({e.tag, ".valid"}, 32'(VALID), 32'(e.valid));
            check({e.tag, ".ch"}, 32'(CH), 32'(e.ch));
            check({e.tag, ".busy"}, 32'(BUSY), 32'(e.busy));
            check({e.tag, ".done"}, 32'(DONE), 32'(e.done));
            check({e.tag, ".err"}, 32'(ERR), 32'(e.err));
        end
    end
    initial begin
        for (int k = 0; k < NCH; k++) in_v[k*8 +: 8] = 8'(8'h10 + k);
        cyc(1, 0, 0, 0, 0, 0, ex("rst0", 0, 0, 0, 0, 0, 0));
        cyc(1, 0, 0, 0, 0, 0, ex("rst1", 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < NCH; k++)
            cyc(0, 0, 4'(k), 0, 0, 0, ex($sformatf("dir%0d", k), 8'(8'h10 + k), 1, 4'(k), 0, 0, 0));
        cyc(0, 0, 5, 0, 0, 0, ex("dir5", 8'h15, 1, 5, 0, 0, 0));
        cyc(0, 0, 12, 0, 0, 1, ex("oor12", 8'h15, 0, 5, 0, 0, 1));
        cyc(0, 0, 3, 0, 0, 0, ex("dir3", 8'h13, 1, 3, 0, 0, 0));
        cyc(0, 1, 0, 0, 0, 0, ex("seqidle", 8'h13, 0, 3, 0, 0, 0));
        cyc(0, 1, 0, 1, 10, 1, ex("full0", 8'h10, 1, 0, 1, 0, 0));
        for (int k = 1; k <= 10; k++)
            cyc(0, k != 5, 4'(k), k == 5, 2, 1,
                ex($sformatf("full%0d", k), 8'(8'h10 + k), 1, 4'(k), 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("fulldone", 8'h1A, 0, 10, 0, 1, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("fullpost", 8'h1A, 0, 10, 0, 0, 0));
        cyc(0, 1, 0, 1, 3, 0, ex("bp0", 8'h10, 1, 0, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("bp1", 8'h11, 1, 1, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 0, ex("stall0", 8'h11, 1, 1, 1, 0, 0));
        in_v[8 +: 8] = 8'hEE;
        cyc(0, 1, 0, 0, 0, 0, ex("stall1", 8'h11, 1, 1, 1, 0, 0));
        cyc(0, 1, 0, 1, 0, 0, ex("stall2", 8'h11, 1, 1, 1, 0, 0));
        in_v[8 +: 8] = 8'h11;
        cyc(0, 1, 0, 0, 0, 1, ex("bp2", 8'h12, 1, 2, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("bp3", 8'h13, 1, 3, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("bpdone", 8'h13, 0, 3, 0, 1, 0));
        cyc(0, 1, 0, 1, 0, 1, ex("one0", 8'h10, 1, 0, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("onedone", 8'h10, 0, 0, 0, 1, 0));
        cyc(0, 1, 0, 1, 11, 1, ex("lasterr", 8'h10, 0, 0, 0, 0, 1));
        cyc(0, 1, 0, 0, 0, 1, ex("errhold", 8'h10, 0, 0, 0, 0, 1));
        cyc(0, 1, 0, 1, 10, 1, ex("ab0", 8'h10, 1, 0, 1, 0, 0));
        for (int k = 1; k <= 4; k++)
            cyc(0, 1, 0, 0, 0, 1, ex($sformatf("ab%0d", k), 8'(8'h10 + k), 1, 4'(k), 1, 0, 0));
        cyc(1, 1, 0, 1, 10, 1, ex("abrst", 0, 0, 0, 0, 0, 0));
        cyc(0, 1, 0, 1, 2, 1, ex("re0", 8'h10, 1, 0, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("re1", 8'h11, 1, 1, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("re2", 8'h12, 1, 2, 1, 0, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("redone", 8'h12, 0, 2, 0, 1, 0));
        cyc(0, 1, 0, 0, 0, 1, ex("repost", 8'h12, 0, 2, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #3;
        check("drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
